// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg: shared types and constants for the instruction-fetch stage.
//   if_state_e : fetch FSM states (IDLE, FETCH, HOLD, DROP)
//   NOP_INSTR  : encoding loaded into IF/ID on reset or squash
//   PC_STEP_DEF: default byte increment from one PC to the next
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int unsigned PC_STEP_DEF = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg: IF/ID pipeline register.
//   clk, rst     : clock, async active-high reset (to NOP / invalid)
//   i_load       : capture i_instr / i_pc_plus4 and mark valid
//   i_stall      : hold current contents
//   i_flush      : squash to NOP / invalid (highest priority)
//   i_instr      : instruction to capture
//   i_pc_plus4   : PC+step to capture
//   o_instr, o_pc_plus4, o_valid : registered IF/ID contents
// Neither load nor stall inserts a bubble (valid drops, payload kept).
// ---------------------------------------------------------------------------
module if_id_reg
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic              r_valid;

    // Priority: flush > stall > load > bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= DATA_W'(NOP_INSTR);
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= DATA_W'(NOP_INSTR);
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr    <= i_instr;
                r_pc_plus4 <= i_pc_plus4;
                r_valid    <= 1'b1;
            end else begin
                r_valid    <= 1'b0;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage between the PC register and IF/ID.
//   clk, rst              : clock, async active-high reset
//   pc_in                 : current PC (PC register updates on negedge)
//   pc_advance            : comb, one pulse per accepted instruction
//   pc_plus4              : comb, pc_in + PC_STEP (wraps)
//   imem_req, imem_addr   : comb, instruction-memory request
//   imem_rdata, imem_ack  : memory response, ack may come same cycle
//   stall_in, flush_in    : hazard hold / branch squash (flush wins)
//   id_instr, id_pc_plus4, id_valid : IF/ID register contents
// Optional macro IF_PERF_CNT_EN adds fetch_count and stall_count outputs.
// ---------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_STEP = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic              id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    if_state_e         r_state;
    if_state_e         w_next_state;
    logic [DATA_W-1:0] r_hold_reg;
    logic [ADDR_W-1:0] r_hold_pc4;
    logic [ADDR_W-1:0] r_drop_addr;

    logic              w_load;
    logic              w_from_hold;
    logic              w_cap_hold;
    logic              w_cap_drop;
    logic [DATA_W-1:0] w_ld_instr;
    logic [ADDR_W-1:0] w_ld_pc4;

    assign pc_plus4 = pc_in + ADDR_W'(PC_STEP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake and IF/ID control
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        imem_addr    = pc_in;
        pc_advance   = 1'b0;
        w_load       = 1'b0;
        w_from_hold  = 1'b0;
        w_cap_hold   = 1'b0;
        w_cap_drop   = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (flush_in) begin
                    // An unacked request must still complete; remember where it went
                    if (!imem_ack) begin
                        w_cap_drop   = 1'b1;
                        w_next_state = DROP;
                    end
                end else if (imem_ack) begin
                    if (stall_in) begin
                        w_cap_hold   = 1'b1;
                        w_next_state = HOLD;
                    end else begin
                        w_load     = 1'b1;
                        pc_advance = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (flush_in) begin
                    w_next_state = FETCH;
                end else if (!stall_in) begin
                    w_load       = 1'b1;
                    w_from_hold  = 1'b1;
                    pc_advance   = 1'b1;
                    w_next_state = FETCH;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
                if (imem_ack) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Parked instruction for a stalled ack, and address of a squashed fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_reg  <= '0;
            r_hold_pc4  <= '0;
            r_drop_addr <= '0;
        end else begin
            if (w_cap_hold) begin
                r_hold_reg <= imem_rdata;
                r_hold_pc4 <= pc_plus4;
            end
            if (w_cap_drop) begin
                r_drop_addr <= pc_in;
            end
        end
    end

    assign w_ld_instr = w_from_hold ? r_hold_reg : imem_rdata;
    assign w_ld_pc4   = w_from_hold ? r_hold_pc4 : pc_plus4;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_stall    (stall_in),
        .i_flush    (flush_in),
        .i_instr    (w_ld_instr),
        .i_pc_plus4 (w_ld_pc4),
        .o_instr    (id_instr),
        .o_pc_plus4 (id_pc_plus4),
        .o_valid    (id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Accepted-instruction and waiting-cycle counters, free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (pc_advance) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if ((r_state == HOLD) || ((r_state == FETCH) && !imem_ack)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: self-checking bench for if_stage. Inputs change on negedge,
// combinational outputs are read 1-2 ns later, registered outputs 1 ns after
// posedge. Define IF_PERF_CNT_EN to also cover the performance counters.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] exp_instr;

    always #5 clk = ~clk;

    if_stage #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .PC_STEP (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .pc_plus4    (pc_plus4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic s, input logic f,
                         input logic a, input logic [31:0] d);
        pc_in      = pc;
        stall_in   = s;
        flush_in   = f;
        imem_ack   = a;
        imem_rdata = d;
        #1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic next_drive();
        @(negedge clk);
    endtask

    // Reset pulse; returns at a negedge with the stage in FETCH
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (id_instr !== 32'h0) begin errs++; $display("FAIL reset_instr: got %h exp %h", id_instr, 32'h0); end
        vecs++; if (id_pc_plus4 !== 32'h0) begin errs++; $display("FAIL reset_pc4: got %h exp %h", id_pc_plus4, 32'h0); end
        vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b exp 0", id_valid); end
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL reset_adv: got %b exp 0", pc_advance); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL idle_req: got %b exp 0", imem_req); end
        @(posedge clk);
        @(negedge clk);
        #1;
        vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL fetch_start_req: got %b exp 1", imem_req); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        logic [31:0] w;
        logic [31:0] e4;
        for (int i = 0; i < 4; i++) begin
            pc = (i == 3) ? 32'hFFFF_FFFC : 32'(4 * i);
            e4 = (i == 3) ? 32'h0 : 32'(4 * i + 4);
            w  = $urandom;
            drive(pc, 1'b0, 1'b0, 1'b1, w);
            vecs++; if (pc_advance !== 1'b1) begin errs++; $display("FAIL zw_adv[%0d]: got %b exp 1", i, pc_advance); end
            vecs++; if (imem_addr !== pc) begin errs++; $display("FAIL zw_addr[%0d]: got %h exp %h", i, imem_addr, pc); end
            vecs++; if (pc_plus4 !== e4) begin errs++; $display("FAIL zw_pcplus4[%0d]: got %h exp %h", i, pc_plus4, e4); end
            edge_sample();
            vecs++; if (id_instr !== w) begin errs++; $display("FAIL zw_instr[%0d]: got %h exp %h", i, id_instr, w); end
            vecs++; if (id_pc_plus4 !== e4) begin errs++; $display("FAIL zw_idpc4[%0d]: got %h exp %h", i, id_pc_plus4, e4); end
            vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL zw_valid[%0d]: got %b exp 1", i, id_valid); end
            next_drive();
        end
    endtask

    task automatic test_latency();
        logic        a;
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            a = (i == 2);
            w = $urandom;
            drive(32'h40, 1'b0, 1'b0, a, w);
            vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL lat_req[%0d]: got %b exp 1", i, imem_req); end
            vecs++; if (imem_addr !== 32'h40) begin errs++; $display("FAIL lat_addr[%0d]: got %h exp 40", i, imem_addr); end
            vecs++; if (pc_advance !== a) begin errs++; $display("FAIL lat_adv[%0d]: got %b exp %b", i, pc_advance, a); end
            edge_sample();
            if (i < 2) begin
                vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL lat_bubble[%0d]: got %b exp 0", i, id_valid); end
            end else begin
                exp_instr = w;
                vecs++; if (id_instr !== w) begin errs++; $display("FAIL lat_instr: got %h exp %h", id_instr, w); end
                vecs++; if (id_pc_plus4 !== 32'h44) begin errs++; $display("FAIL lat_pc4: got %h exp 44", id_pc_plus4); end
                vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL lat_valid: got %b exp 1", id_valid); end
            end
            next_drive();
        end
    endtask

    task automatic test_stall_hold();
        drive(32'h48, 1'b1, 1'b0, 1'b1, 32'h2108_000A);
        vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL hold_ack_adv: got %b exp 0", pc_advance); end
        edge_sample();
        next_drive();
        for (int i = 0; i < 3; i++) begin
            drive(32'h48, 1'b1, 1'b0, 1'b0, $urandom);
            vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL hold_req[%0d]: got %b exp 0", i, imem_req); end
            vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL hold_adv[%0d]: got %b exp 0", i, pc_advance); end
            edge_sample();
            vecs++; if (id_instr !== exp_instr) begin errs++; $display("FAIL hold_instr[%0d]: got %h exp %h", i, id_instr, exp_instr); end
            vecs++; if (id_pc_plus4 !== 32'h44) begin errs++; $display("FAIL hold_pc4[%0d]: got %h exp 44", i, id_pc_plus4); end
            vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL hold_valid[%0d]: got %b exp 1", i, id_valid); end
            next_drive();
        end
        drive(32'h48, 1'b0, 1'b0, 1'b0, $urandom);
        vecs++; if (pc_advance !== 1'b1) begin errs++; $display("FAIL release_adv: got %b exp 1", pc_advance); end
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL release_req: got %b exp 0", imem_req); end
        edge_sample();
        vecs++; if (id_instr !== 32'h2108_000A) begin errs++; $display("FAIL release_instr: got %h exp 2108000a", id_instr); end
        vecs++; if (id_pc_plus4 !== 32'h4C) begin errs++; $display("FAIL release_pc4: got %h exp 4c", id_pc_plus4); end
        vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL release_valid: got %b exp 1", id_valid); end
        next_drive();
    endtask

    task automatic test_flush_drop();
        drive(32'h80, 1'b0, 1'b0, 1'b0, $urandom);
        vecs++; if (imem_addr !== 32'h80) begin errs++; $display("FAIL fl_addr0: got %h exp 80", imem_addr); end
        edge_sample();
        next_drive();
        drive(32'h80, 1'b0, 1'b1, 1'b0, $urandom);
        vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL fl_adv: got %b exp 0", pc_advance); end
        edge_sample();
        vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL fl_valid: got %b exp 0", id_valid); end
        vecs++; if (id_instr !== 32'h0) begin errs++; $display("FAIL fl_instr: got %h exp 0", id_instr); end
        next_drive();
        for (int i = 0; i < 2; i++) begin
            drive(32'h200, 1'b0, 1'b0, (i == 1), $urandom);
            vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL drop_req[%0d]: got %b exp 1", i, imem_req); end
            vecs++; if (imem_addr !== 32'h80) begin errs++; $display("FAIL drop_addr[%0d]: got %h exp 80", i, imem_addr); end
            vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL drop_adv[%0d]: got %b exp 0", i, pc_advance); end
            edge_sample();
            vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL drop_valid[%0d]: got %b exp 0", i, id_valid); end
            next_drive();
        end
        drive(32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL refetch_req: got %b exp 1", imem_req); end
        vecs++; if (imem_addr !== 32'h200) begin errs++; $display("FAIL refetch_addr: got %h exp 200", imem_addr); end
        edge_sample();
        next_drive();
    endtask

    task automatic test_stall_flush();
        logic [31:0] w;
        w = $urandom;
        drive(32'h200, 1'b0, 1'b0, 1'b1, w);
        edge_sample();
        vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL sf_pre_valid: got %b exp 1", id_valid); end
        next_drive();
        drive(32'h204, 1'b1, 1'b1, 1'b1, $urandom);
        vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL sf_adv: got %b exp 0", pc_advance); end
        edge_sample();
        vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL sf_valid: got %b exp 0", id_valid); end
        vecs++; if (id_instr !== 32'h0) begin errs++; $display("FAIL sf_instr: got %h exp 0", id_instr); end
        next_drive();
        drive(32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL sf_state_fetch: req got %b exp 1", imem_req); end
        vecs++; if (imem_addr !== 32'h204) begin errs++; $display("FAIL sf_addr: got %h exp 204", imem_addr); end
        edge_sample();
        next_drive();
    endtask

    task automatic test_reset_mid_hold();
        drive(32'h300, 1'b1, 1'b0, 1'b1, $urandom);
        edge_sample();
        next_drive();
        drive(32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mh_in_hold: req got %b exp 0", imem_req); end
        #2;
        rst = 1'b1;
        #1;
        vecs++; if (id_instr !== 32'h0) begin errs++; $display("FAIL mh_instr: got %h exp 0", id_instr); end
        vecs++; if (id_pc_plus4 !== 32'h0) begin errs++; $display("FAIL mh_pc4: got %h exp 0", id_pc_plus4); end
        vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL mh_valid: got %b exp 0", id_valid); end
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mh_req: got %b exp 0", imem_req); end
        stall_in = 1'b0;
        #1;
        vecs++; if (pc_advance !== 1'b0) begin errs++; $display("FAIL mh_adv: got %b exp 0", pc_advance); end
`ifdef IF_PERF_CNT_EN
        vecs++; if (fetch_count !== 32'h0) begin errs++; $display("FAIL mh_fetch_cnt: got %0d exp 0", fetch_count); end
        vecs++; if (stall_count !== 32'h0) begin errs++; $display("FAIL mh_stall_cnt: got %0d exp 0", stall_count); end
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mh_idle_req: got %b exp 0", imem_req); end
        @(posedge clk);
        @(negedge clk);
        #1;
        vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL mh_resume_req: got %b exp 1", imem_req); end
        next_drive();
    endtask

    // Random stall/flush/latency against a stream-level model: every accepted
    // instruction is the memory word at the architectural PC, and the PC
    // moves by one step per acceptance or jumps to a new target on flush.
    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] m_instr;
        logic [31:0] m_pc4;
        logic        m_valid;
        logic        s;
        logic        f;
        logic        a;
        logic        adv;
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] tgt;
        int          fetches;
        do_reset();
        pc      = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        pend    = 1'b0;
        pend_addr = 32'h0;
        fetches = 0;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(3) == 0);
            f = ($urandom_range(15) == 0);
            drive(pc, s, f, 1'b0, 32'h0);
            if (pend) begin
                vecs++; if ({imem_req, imem_addr} !== {1'b1, pend_addr}) begin
                    errs++; $display("FAIL rnd_req_stable[%0d]: got %b/%h exp 1/%h", n, imem_req, imem_addr, pend_addr);
                end
            end
            a = imem_req && ($urandom_range(1) == 1);
            imem_ack   = a;
            imem_rdata = mem_word(imem_addr);
            #1;
            adv       = pc_advance;
            pend      = imem_req && !a;
            pend_addr = imem_addr;
            if (adv) begin
                vecs++; if (s || f) begin errs++; $display("FAIL rnd_adv_blocked[%0d]: got 1 exp 0 (stall=%b flush=%b)", n, s, f); end
            end
            if (f) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else if (adv) begin
                m_instr = mem_word(pc);
                m_pc4   = pc + 32'd4;
                m_valid = 1'b1;
                fetches++;
            end else if (!s) begin
                m_valid = 1'b0;
            end
            edge_sample();
            vecs++; if (id_valid !== m_valid) begin errs++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, id_valid, m_valid); end
            if (m_valid || f) begin
                vecs++; if (id_instr !== m_instr) begin errs++; $display("FAIL rnd_instr[%0d]: got %h exp %h", n, id_instr, m_instr); end
            end
            if (m_valid) begin
                vecs++; if (id_pc_plus4 !== m_pc4) begin errs++; $display("FAIL rnd_pc4[%0d]: got %h exp %h", n, id_pc_plus4, m_pc4); end
            end
`ifdef IF_PERF_CNT_EN
            vecs++; if (fetch_count !== 32'(fetches)) begin errs++; $display("FAIL rnd_fetch_cnt[%0d]: got %0d exp %0d", n, fetch_count, fetches); end
`endif
            next_drive();
            if (adv) pc = pc + 32'd4;
            if (f) begin
                tgt = $urandom;
                pc  = tgt & 32'hFFFF_FFFC;
            end
        end
        vecs++; if (fetches < 40) begin errs++; $display("FAIL rnd_progress: got %0d accepted exp at least 40", fetches); end
    endtask

    initial begin
        rst        = 1'b1;
        pc_in      = 32'h0;
        stall_in   = 1'b0;
        flush_in   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exp_instr  = 32'h0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_flush_drop();
        test_stall_flush();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register.
- Takes the current PC, fetches the instruction from instruction memory over a req/ack handshake (variable latency), and loads the IF/ID pipeline register.
- Drives pc_advance, which gates the PC register write. The PC register updates on negedge clk, so pc_in is stable again by the next posedge.
- Honours stall from the hazard unit and flush from branch/jump resolution.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction width.
- PC_STEP, 4, byte increment added to the fetched PC.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_W  current PC from PC register.
- pc_advance  out  1  combinational; high for exactly one cycle per accepted instruction; enables PC write.
- pc_plus4  out  ADDR_W  combinational; pc_in + PC_STEP, fed to next-PC mux.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_rdata  in  DATA_W  fetched instruction; valid when imem_ack=1.
- imem_ack  in  1  completes the current request.
- stall_in  in  1  hold IF/ID contents; do not advance PC.
- flush_in  in  1  squash IF/ID and any in-flight fetch.
- id_instr  out  DATA_W  IF/ID instruction.
- id_pc_plus4  out  ADDR_W  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, any state): state=IDLE, id_instr=0 (NOP), id_pc_plus4=0, id_valid=0, hold_reg=0, drop_addr=0.
- Combinational outputs during reset: imem_req=0, pc_advance=0.
- States: IDLE, FETCH, HOLD, DROP.
- IDLE:
  - imem_req=0.
  - Next cycle -> FETCH. Fetch starts one cycle after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc_in. The request stays asserted and address stable until ack.
  - Zero-wait ack in the same cycle is legal.
  - ack & !stall & !flush: IF/ID <= {imem_rdata, pc_in+PC_STEP}, id_valid<=1, pc_advance=1, stay FETCH. Sustained throughput is 1 instr/cycle.
  - ack & stall & !flush: hold_reg<=imem_rdata, hold_pc4<=pc_in+PC_STEP, IF/ID unchanged, pc_advance=0, -> HOLD.
  - !ack & !stall: id_valid<=0 (bubble).
  - !ack & stall: IF/ID unchanged.
- HOLD:
  - imem_req=0.
  - While stall: stay; IF/ID unchanged.
  - On !stall: IF/ID <= {hold_reg, hold_pc4}, id_valid<=1, pc_advance=1, -> FETCH.
- flush_in has highest priority in every state:
  - id_valid<=0 and id_instr<=0 next cycle.
  - pc_advance=0; the upstream PC mux loads the target.
  - FETCH & !ack: drop_addr<=pc_in, -> DROP. The handshake is never abandoned.
  - FETCH & ack: data discarded, stay FETCH.
  - HOLD: hold_reg discarded, -> FETCH.
- DROP:
  - imem_req=1, imem_addr=drop_addr.
  - On ack: data discarded, -> FETCH.
  - id_valid stays 0.
  - A further flush while in DROP stays in DROP.
- Stall and flush together: flush wins.
- Addition wraps modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0).
- pc_advance never asserts in IDLE or DROP.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_count[31:0] (increments on each pc_advance) and stall_count[31:0] (increments each cycle state==HOLD or (FETCH & !ack)).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package if_pkg holds:
  - the state enum (IDLE, FETCH, HOLD, DROP);
  - NOP_INSTR=32'h0000_0000;
  - PC_STEP default.
- One natural sub-module, if_id_reg: the IF/ID register with load/stall/flush inputs and async reset to NOP/invalid.

Test Plan:
- Reset then zero-wait memory, pc_in 0,4,8 -> pc_advance=1 every cycle; id_instr follows the memory words one cycle later; id_pc_plus4=4,8,12; id_valid=1.
- 3-cycle ack latency at pc_in=0x40 -> imem_req held 3 cycles with addr 0x40; id_valid=0 bubbles; single pc_advance on the ack cycle; id_pc_plus4=0x44.
- Ack with stall_in=1 for 4 cycles, rdata=0x2108000A -> state HOLD, imem_req=0, IF/ID unchanged; on stall release id_instr=0x2108000A, pc_advance=1.
- flush_in during outstanding fetch of 0x80, pc_in then changes to 0x200 -> imem_addr stays 0x80 until ack, data dropped, id_valid=0; next request addr=0x200.
- Simultaneous stall_in=1 and flush_in=1 with ack -> id_valid=0, state FETCH, pc_advance=0.
- rst asserted mid-HOLD -> outputs immediately NOP/0/invalid, imem_req=0; fetch resumes one cycle after release. With IF_PERF_CNT_EN, counters read 0.
